// File: rtl/fir_pkg.sv
// Shared constants and sample type for the FIR filter chain (fir13_filter and its decimating buffer).
package fir_pkg;
    localparam int FIR_DW      = 8;
    localparam int DEC_DEFAULT = 4;
    localparam int FIFO_DEPTH  = 8;
    localparam int FIFO_AW     = $clog2(FIFO_DEPTH);

    typedef logic signed [FIR_DW-1:0] sample_t;
endpackage

// File: rtl/fir_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head word is visible whenever the FIFO is non-empty.
module fir_sync_fifo #(
    parameter int DW    = 8,
    parameter int AW    = 3,
    parameter int DEPTH = 1 << AW
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_level;
    logic          w_full;
    logic          w_empty;
    logic          w_rd;
    logic          w_wr;

    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_rd    = pop && !w_empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the write.
    assign w_wr    = push && (!w_full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wrPtr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_rd) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign rdata = w_empty ? '0 : r_mem[r_rdPtr];
    assign level = r_level;
    assign full  = w_full;
    assign empty = w_empty;
endmodule

// File: rtl/fir_decim_buffer.sv
// Keeps one FIR output sample in every DEC and buffers the kept samples in a FWFT FIFO
// drained over valid/ready, with a fill level and a sticky overflow flag.
module fir_decim_buffer
    import fir_pkg::*;
#(
    parameter int DW    = FIR_DW,
    parameter int DEC   = DEC_DEFAULT,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 in_en,
    input  logic signed [DW-1:0] x_in,
    output logic signed [DW-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [AW:0]          level,
    output logic                 ovf,
    input  logic                 clr_ovf
);
    localparam int PW = (DEC > 1) ? $clog2(DEC) : 1;

    logic [PW-1:0] r_phase;
    logic          r_ovf;
    logic          w_push;
    logic          w_phaseLast;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;
    logic [DW-1:0] w_rdata;

    assign w_push      = in_en && (r_phase == '0);
    assign w_phaseLast = (r_phase == PW'(DEC - 1));
    // A full FIFO only loses the sample when nothing is being popped this cycle.
    assign w_drop      = w_push && w_full && !m_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_phase <= '0;
        end else if (in_en) begin
            r_phase <= w_phaseLast ? '0 : r_phase + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    fir_sync_fifo #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (w_push),
        .pop   (m_ready),
        .wdata (x_in),
        .rdata (w_rdata),
        .level (level),
        .full  (w_full),
        .empty (w_empty)
    );

    assign m_data  = w_rdata;
    assign m_valid = !w_empty;
    assign ovf     = r_ovf;
endmodule
